serial_to_parallel_lanes: RTL and testbench

Parametrised N-lane receive-side deserializer for the PHY. Each lane takes one serial bit per clk_8f cycle, MSB first. It hunts for the COM character (default 0xBC) at any bit offset, locks byte alignment once it has seen LOCK_COUNT consecutive aligned COMs, then delivers bytes with per-lane valid. It generalises the fixed two-lane, 8-bit path to LANES lanes and WIDTH-bit symbols, and adds per-lane and aggregate lock status.

---
 rtl/phy_pkg.sv | 18 +
 rtl/stp_lane.sv | 83 ++++++++
 rtl/serial_to_parallel_lanes.sv | 37 +++
 tb/tb_serial_to_parallel_lanes.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Shared definitions for the PHY receive deserializer.
// Lane FSM encodings, default alignment character and counter sizing.
package phy_pkg;

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;

    localparam logic [7:0] COM_DEFAULT = 8'hBC;

    localparam int DEF_WIDTH = 8;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/stp_lane.sv
// One deserializer lane: sliding COM search, alignment lock and
// byte-boundary output registers.
module stp_lane
    import phy_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM_CHAR   = WIDTH'(COM_DEFAULT),
    parameter int               LOCK_COUNT = 4
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             active
);

    localparam int             BW   = cnt_width(WIDTH);
    localparam logic [BW-1:0]  LAST = BW'(WIDTH - 1);
    localparam logic [3:0]     LOCK = 4'(LOCK_COUNT);

    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] nxt;
    logic [BW-1:0]    bit_cnt;
    logic [3:0]       com_cnt;
    logic [1:0]       state;
    logic             is_com;
    logic             boundary;

    assign nxt      = {shift[WIDTH-2:0], serial_in};
    assign is_com   = (nxt == COM_CHAR);
    assign boundary = (bit_cnt == LAST);
    assign active   = (state == ACTIVE);

    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            shift   <= '0;
            bit_cnt <= '0;
            com_cnt <= '0;
            state   <= HUNT;
            data    <= '0;
            valid   <= 1'b0;
        end else begin
            shift   <= nxt;
            bit_cnt <= boundary ? '0 : bit_cnt + 1'b1;
            case (state)
                HUNT: begin
                    // A fresh match re-anchors the boundary, even if the
                    // old count would also have wrapped on this edge.
                    if (is_com) begin
                        bit_cnt <= '0;
                        com_cnt <= 4'd1;
                        state   <= (LOCK == 4'd1) ? ACTIVE : CHECK;
                    end
                end
                CHECK: begin
                    if (boundary) begin
                        if (is_com) begin
                            com_cnt <= com_cnt + 4'd1;
                            if (com_cnt + 4'd1 == LOCK)
                                state <= ACTIVE;
                        end else begin
                            com_cnt <= '0;
                            state   <= HUNT;
                        end
                    end
                end
                ACTIVE: begin
                    if (boundary) begin
                        if (is_com) begin
                            valid <= 1'b0;
                        end else begin
                            data  <= nxt;
                            valid <= 1'b1;
                        end
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: rtl/serial_to_parallel_lanes.sv
// N-lane receive deserializer: independent per-lane alignment and
// output, plus an aggregate lock flag.
module serial_to_parallel_lanes
    import phy_pkg::*;
#(
    parameter int               LANES      = 2,
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM_CHAR   = WIDTH'(COM_DEFAULT),
    parameter int               LOCK_COUNT = 4
) (
    input  logic                   clk_8f,
    input  logic                   reset,
    input  logic [LANES-1:0]       serial_in,
    output logic [LANES*WIDTH-1:0] data_out,
    output logic [LANES-1:0]       valid_out,
    output logic [LANES-1:0]       lane_active,
    output logic                   all_active
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        stp_lane #(
            .WIDTH      (WIDTH),
            .COM_CHAR   (COM_CHAR),
            .LOCK_COUNT (LOCK_COUNT)
        ) u_lane (
            .clk_8f    (clk_8f),
            .reset     (reset),
            .serial_in (serial_in[i]),
            .data      (data_out[i*WIDTH +: WIDTH]),
            .valid     (valid_out[i]),
            .active    (lane_active[i])
        );
    end

    assign all_active = &lane_active;

endmodule

// File: tb/tb_serial_to_parallel_lanes.sv
// Scoreboard bench for the lane deserializer: default 2x8-bit instance
// and a 4x10-bit single-COM-lock instance driven side by side.
module tb_serial_to_parallel_lanes;

    logic        clk_8f = 1'b0;
    logic        reset;
    logic [1:0]  serial_in;
    logic [15:0] data_out;
    logic [1:0]  valid_out;
    logic [1:0]  lane_active;
    logic        all_active;
    logic [3:0]  serial_in_w;
    logic [39:0] data_out_w;
    logic [3:0]  valid_out_w;
    logic [3:0]  lane_active_w;
    logic        all_active_w;

    always #5 clk_8f = ~clk_8f;

    serial_to_parallel_lanes dut (
        .clk_8f      (clk_8f),
        .reset       (reset),
        .serial_in   (serial_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .lane_active (lane_active),
        .all_active  (all_active)
    );

    serial_to_parallel_lanes #(
        .LANES      (4),
        .WIDTH      (10),
        .COM_CHAR   (10'h17C),
        .LOCK_COUNT (1)
    ) dut_w (
        .clk_8f      (clk_8f),
        .reset       (reset),
        .serial_in   (serial_in_w),
        .data_out    (data_out_w),
        .valid_out   (valid_out_w),
        .lane_active (lane_active_w),
        .all_active  (all_active_w)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Lanes 0-1 belong to dut, lanes 2-5 to dut_w.
    bit          bitq [6][$];
    logic [15:0] expq [6][$];
    int          lock_cyc [6];
    int          hi_cnt [6];
    int          bad_valid [6];
    int          all_a_cyc;
    int          all_w_cyc;
    int          cyc;
    logic        v0_log [0:127];
    logic [7:0]  d0_log [0:127];

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int lw(input int l);
        return (l < 2) ? 8 : 10;
    endfunction

    function automatic logic [15:0] lcom(input int l);
        return (l < 2) ? 16'h00BC : 16'h017C;
    endfunction

    task automatic push_sym(input int l, input logic [15:0] s,
                            input bit exp_out);
        for (int b = lw(l) - 1; b >= 0; b--)
            bitq[l].push_back(s[b]);
        if (exp_out)
            expq[l].push_back(s);
    endtask

    task automatic push_junk(input int l, input logic [15:0] s,
                             input int n);
        for (int b = n - 1; b >= 0; b--)
            bitq[l].push_back(s[b]);
    endtask

    task automatic new_test();
        for (int l = 0; l < 6; l++) begin
            bitq[l].delete();
            expq[l].delete();
            lock_cyc[l]  = -1;
            hi_cnt[l]    = 0;
            bad_valid[l] = 0;
        end
        all_a_cyc = -1;
        all_w_cyc = -1;
        cyc = 0;
        for (int k = 0; k < 128; k++) begin
            v0_log[k] = 1'b0;
            d0_log[k] = 8'h00;
        end
    endtask

    task automatic end_test(input string name);
        for (int l = 0; l < 6; l++) begin
            check_eq($sformatf("%s_sb_left_l%0d", name, l),
                     expq[l].size(), 0);
            check_eq($sformatf("%s_valid_unlocked_l%0d", name, l),
                     bad_valid[l], 0);
        end
    endtask

    task automatic drive();
        bit b;
        for (int l = 0; l < 6; l++) begin
            if (bitq[l].size() == 0)
                push_sym(l, lcom(l), 1'b0);
            b = bitq[l].pop_front();
            if (l < 2) serial_in[l] = b;
            else       serial_in_w[l-2] = b;
        end
    endtask

    task automatic monitor();
        logic        v;
        logic        a;
        logic [15:0] d;
        logic [15:0] e;
        for (int l = 0; l < 6; l++) begin
            if (l < 2) begin
                v = valid_out[l];
                a = lane_active[l];
                d = {8'h00, data_out[l*8 +: 8]};
            end else begin
                v = valid_out_w[l-2];
                a = lane_active_w[l-2];
                d = {6'h00, data_out_w[(l-2)*10 +: 10]};
            end
            if (a && lock_cyc[l] < 0) lock_cyc[l] = cyc;
            if (v && !a) bad_valid[l]++;
            if (v) begin
                if (hi_cnt[l] % lw(l) == 0) begin
                    check_eq($sformatf("sb_avail_l%0d", l),
                             32'(expq[l].size() > 0), 1);
                    if (expq[l].size() > 0) begin
                        e = expq[l].pop_front();
                        check_eq($sformatf("sb_data_l%0d_c%0d", l, cyc),
                                 d, e);
                    end
                end
                hi_cnt[l]++;
            end else begin
                hi_cnt[l] = 0;
            end
        end
        if (all_active && all_a_cyc < 0) all_a_cyc = cyc;
        if (all_active_w && all_w_cyc < 0) all_w_cyc = cyc;
        if (cyc < 128) begin
            v0_log[cyc] = valid_out[0];
            d0_log[cyc] = data_out[7:0];
        end
    endtask

    // Called at a falling edge; returns at a falling edge.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            drive();
            @(posedge clk_8f);
            #1;
            monitor();
            cyc++;
            @(negedge clk_8f);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        serial_in   = '0;
        serial_in_w = '0;
        repeat (2) @(negedge clk_8f);
        new_test();
        reset = 1'b0;
    endtask

    task automatic check_zero(input string name);
        check_eq({name, "_data"}, data_out, 0);
        check_eq({name, "_valid"}, valid_out, 0);
        check_eq({name, "_active"}, lane_active, 0);
        check_eq({name, "_all"}, all_active, 0);
        check_eq({name, "_w_data"}, data_out_w[31:0], 0);
        check_eq({name, "_w_active"}, lane_active_w, 0);
    endtask

    initial begin
        reset       = 1'b1;
        serial_in   = '0;
        serial_in_w = '0;
        new_test();
        @(posedge clk_8f);
        #1;
        check_zero("reset_state");
        @(negedge clk_8f);
        do_reset();

        // Aligned lane 0, lane 1 offset by three junk bits.
        for (int i = 0; i < 4; i++) push_sym(0, 16'hBC, 1'b0);
        push_sym(0, 16'h90, 1'b1);
        push_sym(0, 16'h0A, 1'b1);
        push_junk(1, 16'h0003, 3);
        for (int i = 0; i < 4; i++) push_sym(1, 16'hBC, 1'b0);
        push_sym(1, 16'h5D, 1'b1);
        run(60);
        check_eq("t1_lock_l0", lock_cyc[0], 31);
        check_eq("t2_lock_l1", lock_cyc[1], 34);
        check_eq("t2_all_active", all_a_cyc, 34);
        check_eq("t1_valid_pre", v0_log[38], 0);
        check_eq("t1_valid_90", v0_log[39], 1);
        check_eq("t1_data_90", d0_log[39], 8'h90);
        check_eq("t1_data_0a", d0_log[47], 8'h0A);
        end_test("t1");

        // Broken COM run must restart the lock count.
        do_reset();
        for (int i = 0; i < 3; i++) push_sym(0, 16'hBC, 1'b0);
        push_sym(0, 16'hAA, 1'b0);
        for (int i = 0; i < 5; i++) push_sym(0, 16'hBC, 1'b0);
        push_sym(0, 16'h77, 1'b1);
        run(90);
        check_eq("t3_lock_l0", lock_cyc[0], 63);
        check_eq("t3_all_active", all_a_cyc, 63);
        check_eq("t3_valid_77", v0_log[79], 1);
        end_test("t3");

        // COM inside payload: valid drops, data holds.
        do_reset();
        for (int i = 0; i < 4; i++) push_sym(0, 16'hBC, 1'b0);
        push_sym(0, 16'h3A, 1'b1);
        push_sym(0, 16'hBC, 1'b0);
        push_sym(0, 16'hAB, 1'b1);
        run(64);
        check_eq("t4_v_3a", v0_log[39], 1);
        check_eq("t4_d_3a", d0_log[39], 8'h3A);
        check_eq("t4_v_hold", v0_log[46], 1);
        check_eq("t4_v_com", v0_log[47], 0);
        check_eq("t4_d_com", d0_log[47], 8'h3A);
        check_eq("t4_v_ab", v0_log[55], 1);
        check_eq("t4_d_ab", d0_log[55], 8'hAB);
        end_test("t4");

        // Asynchronous reset while locked, mid-byte.
        do_reset();
        for (int i = 0; i < 4; i++) push_sym(0, 16'hBC, 1'b0);
        push_sym(0, 16'h11, 1'b1);
        run(45);
        check_eq("t5_pre_active", lane_active, 2'b11);
        end_test("t5a");
        #2;
        reset = 1'b1;
        #1;
        check_zero("t5_async");
        @(negedge clk_8f);
        do_reset();
        for (int i = 0; i < 4; i++) push_sym(0, 16'hBC, 1'b0);
        push_sym(0, 16'h22, 1'b1);
        run(48);
        check_eq("t5_relock_l0", lock_cyc[0], 31);
        check_eq("t5_v_22", v0_log[39], 1);
        end_test("t5b");

        // 4 x 10-bit lanes, lock on first COM, per-lane offsets.
        do_reset();
        for (int j = 0; j < 4; j++) begin
            push_junk(2 + j, 16'h0000, j);
            push_sym(2 + j, 16'h017C, 1'b0);
            push_sym(2 + j, 16'h02A5, 1'b1);
        end
        push_sym(2, 16'h0155, 1'b1);
        run(40);
        for (int j = 0; j < 4; j++)
            check_eq($sformatf("t6_lock_w%0d", j), lock_cyc[2+j], j + 9);
        check_eq("t6_all_active_w", all_w_cyc, 12);
        end_test("t6");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
